// File: rtl/pulse_noise_channel.sv
// rtl/pulse_noise_channel.sv - square/LFSR-noise tone channel with envelope, length counter and tick-paced output
module pulse_noise_channel #(
   parameter int WIDTH     = 16,
   parameter int LEN_WIDTH = 16,
   parameter int ENV_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 tick,
   input  logic                 trigger,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     period,
   input  logic [WIDTH-1:0]     duty_cycle,
   input  logic [WIDTH-1:0]     volume,
   input  logic                 env_dir,
   input  logic [ENV_WIDTH-1:0] env_rate,
   input  logic [LEN_WIDTH-1:0] length,
   output logic [WIDTH-1:0]     wave,
   output logic                 sample_valid,
   output logic                 active
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state, state_next;
   logic [WIDTH-1:0]     phase, shadow_period, shadow_duty, volume_l;
   logic                 mode_l, env_dir_l;
   logic [ENV_WIDTH-1:0] env_rate_l, env_cnt;
   logic [LEN_WIDTH-1:0] len_cnt;
   logic [3:0]           gain;
   logic [14:0]          lfsr;

   logic                 phase_wrap, level;
   logic [WIDTH-1:0]     neg_vol, raw, sample_next;
   logic [WIDTH+3:0]     raw_ext, gain_ext, product;
   logic                 unused_frac;

   // A period of 0 or 1 wraps every tick; the widened add avoids underflow.
   assign phase_wrap = ({1'b0, phase} + (WIDTH+1)'(1)) >= {1'b0, shadow_period};
   assign level      = mode_l ? ~lfsr[0] : (phase < shadow_duty);

   // Negating the most-negative amplitude saturates to the largest positive one.
   assign neg_vol  = (volume_l == {1'b1, {(WIDTH-1){1'b0}}}) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                             : (~volume_l + WIDTH'(1));
   assign raw      = level ? volume_l : neg_vol;
   assign raw_ext  = {{4{raw[WIDTH-1]}}, raw};
   assign gain_ext = {{WIDTH{1'b0}}, gain};
   assign product  = WIDTH'(0) + ($signed(raw_ext) * $signed(gain_ext));
   assign unused_frac = ^product[3:0];

   // Arithmetic shift by 4 then truncate == the upper WIDTH bits of the product.
   assign sample_next = (state == RUN && !trigger) ? product[WIDTH+3:4] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (trigger) state_next = RUN;
         RUN: begin
            if (trigger)                                 state_next = RUN;
            else if (tick && len_cnt == LEN_WIDTH'(1))   state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      active = (state == RUN);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wave          <= '0;
         sample_valid  <= 1'b0;
         phase         <= '0;
         shadow_period <= '0;
         shadow_duty   <= '0;
         volume_l      <= '0;
         mode_l        <= 1'b0;
         env_dir_l     <= 1'b0;
         env_rate_l    <= '0;
         env_cnt       <= '0;
         len_cnt       <= '0;
         gain          <= 4'd0;
         lfsr          <= 15'h7FFF;
      end else begin
         sample_valid <= tick;
         if (tick) wave <= sample_next;
         if (trigger) begin
            shadow_period <= period;
            shadow_duty   <= duty_cycle;
            mode_l        <= mode;
            volume_l      <= volume;
            env_dir_l     <= env_dir;
            env_rate_l    <= env_rate;
            len_cnt       <= length;
            phase         <= '0;
            env_cnt       <= '0;
            lfsr          <= 15'h7FFF;
            gain          <= (env_dir && env_rate != '0) ? 4'd0 : 4'd15;
         end else if (tick && state == RUN) begin
            // Live period/duty are only sampled at a wrap so edges never glitch.
            if (phase_wrap) begin
               phase         <= '0;
               shadow_period <= period;
               shadow_duty   <= duty_cycle;
               lfsr          <= {lfsr[0] ^ lfsr[1], lfsr[14:1]};
            end else begin
               phase <= phase + WIDTH'(1);
            end
            if (env_rate_l != '0) begin
               if (env_cnt == env_rate_l - ENV_WIDTH'(1)) begin
                  env_cnt <= '0;
                  if (env_dir_l && gain != 4'd15)      gain <= gain + 4'd1;
                  else if (!env_dir_l && gain != 4'd0) gain <= gain - 4'd1;
               end else begin
                  env_cnt <= env_cnt + ENV_WIDTH'(1);
               end
            end
            if (len_cnt != '0) len_cnt <= len_cnt - LEN_WIDTH'(1);
         end
      end
   end

endmodule
